// File: rtl/mc_pkg.sv
// Shared encodings and helpers for the multi-cycle RV32I controller/datapath pair.
package mc_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_RTYPE = 2'b01,
    ALU_OP_ITYPE = 2'b10,
    ALU_OP_ADD_B = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'b00,
    SRC_B_IMM  = 2'b01,
    SRC_B_FOUR = 2'b10,
    SRC_B_ZERO = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_DATA = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_fn_e;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_J, IMM_U
  } imm_fmt_e;

  // alt is IR[30]; I-type never turns 000 into sub.
  function automatic alu_fn_e decode_alu(input logic [2:0] funct3, input logic alt,
                                         input logic is_itype);
    alu_fn_e fn;
    fn = ALU_ADD;
    case (funct3)
      3'b000:  fn = (alt && !is_itype) ? ALU_SUB : ALU_ADD;
      3'b001:  fn = ALU_SLL;
      3'b010:  fn = ALU_SLT;
      3'b011:  fn = ALU_SLTU;
      3'b100:  fn = ALU_XOR;
      3'b101:  fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  fn = ALU_OR;
      default: fn = ALU_AND;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: x0 reads zero, two combinational read ports, no write bypass.
module mc_regfile
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a_c,
  output logic [XLEN-1:0]   rdata_b_c
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) regs[waddr] <= wdata;
  end

  assign rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I datapath; MC_DP_TRACE_EN adds a registered retirement trace port.
module mc_datapath
  import mc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel_mem_addr,
  input  logic            we_ir,
  input  logic            we_pc,
  input  logic            we_pc_plus_4,
  input  logic            we_alu_reg,
  input  logic            we_original_pc,
  input  logic            we_rf,
  input  logic            we_mem,
  input  logic            sel_alu_src_a,
  input  logic            sel_original_pc,
  input  logic [1:0]      sel_alu_src_b,
  input  logic [1:0]      alu_op,
  input  logic [1:0]      sel_result,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
`ifdef MC_DP_TRACE_EN
  ,
  output logic              trace_valid,
  output logic [XLEN-1:0]   trace_pc,
  output logic [REG_AW-1:0] trace_rd,
  output logic [XLEN-1:0]   trace_data
`endif
);

  logic [XLEN-1:0] pc, ir, original_pc, pc_plus_4, alu_reg, data_reg, a_reg, b_reg;
  logic [XLEN-1:0] rf_rd_a, rf_rd_b;
  logic [XLEN-1:0] imm, src_a, src_b, alu_result, result;
  imm_fmt_e        imm_fmt;
  alu_fn_e         alu_fn;
  logic            rf_we;

  assign opcode    = ir[6:0];
  assign mem_addr  = sel_mem_addr ? alu_reg : pc;
  assign mem_wdata = b_reg;
  assign mem_we    = we_mem & ~rst;
  // Reset aborts the instruction in flight, including a pending writeback.
  assign rf_we     = we_rf & ~rst;

  mc_regfile u_rf (
    .clk       (clk),
    .we        (rf_we),
    .waddr     (ir[11:7]),
    .wdata     (result),
    .raddr_a   (ir[19:15]),
    .raddr_b   (ir[24:20]),
    .rdata_a_c (rf_rd_a),
    .rdata_b_c (rf_rd_b)
  );

  // Immediate generator.
  always_comb begin
    imm_fmt = IMM_NONE;
    imm     = '0;
    case (ir[6:0])
      OP_LOAD, OP_IMM: imm_fmt = IMM_I;
      OP_STORE:        imm_fmt = IMM_S;
      OP_JAL:          imm_fmt = IMM_J;
      OP_LUI:          imm_fmt = IMM_U;
      default:         imm_fmt = IMM_NONE;
    endcase
    case (imm_fmt)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

  // Operand muxes and ALU.
  always_comb begin
    src_a = sel_alu_src_a ? a_reg : (sel_original_pc ? original_pc : pc);
    src_b = '0;
    case (src_b_e'(sel_alu_src_b))
      SRC_B_REG:  src_b = b_reg;
      SRC_B_IMM:  src_b = imm;
      SRC_B_FOUR: src_b = 32'd4;
      default:    src_b = '0;
    endcase

    alu_fn = ALU_ADD;
    case (alu_op_e'(alu_op))
      ALU_OP_RTYPE: alu_fn = decode_alu(ir[14:12], ir[30], 1'b0);
      ALU_OP_ITYPE: alu_fn = decode_alu(ir[14:12], ir[30], 1'b1);
      default:      alu_fn = ALU_ADD;
    endcase

    alu_result = '0;
    case (alu_fn)
      ALU_ADD:  alu_result = src_a + src_b;
      ALU_SUB:  alu_result = src_a - src_b;
      ALU_SLL:  alu_result = src_a << src_b[4:0];
      ALU_SLT:  alu_result = 32'($signed(src_a) < $signed(src_b));
      ALU_SLTU: alu_result = 32'(src_a < src_b);
      ALU_XOR:  alu_result = src_a ^ src_b;
      ALU_SRL:  alu_result = src_a >> src_b[4:0];
      ALU_SRA:  alu_result = $signed(src_a) >>> src_b[4:0];
      ALU_OR:   alu_result = src_a | src_b;
      default:  alu_result = src_a & src_b;
    endcase

    result = '0;
    case (result_e'(sel_result))
      RES_ALU:  result = alu_reg;
      RES_DATA: result = data_reg;
      RES_PC4:  result = pc_plus_4;
      default:  result = imm;
    endcase
  end

  // Architectural and staging registers; original_pc samples PC before any same-edge update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= NOP_INSTR;
      original_pc <= '0;
      pc_plus_4   <= '0;
      alu_reg     <= '0;
      data_reg    <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else begin
      if (we_pc)          pc          <= alu_result;
      if (we_ir)          ir          <= mem_rdata;
      if (we_original_pc) original_pc <= pc;
      if (we_pc_plus_4)   pc_plus_4   <= alu_result;
      if (we_alu_reg)     alu_reg     <= alu_result;
      data_reg <= mem_rdata;
      a_reg    <= rf_rd_a;
      b_reg    <= rf_rd_b;
    end
  end

`ifdef MC_DP_TRACE_EN
  // One-cycle record per RF write or store, presented the cycle after it commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_rd    <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= rf_we | mem_we;
      trace_pc    <= original_pc;
      trace_rd    <= mem_we ? '0 : ir[11:7];
      trace_data  <= mem_we ? b_reg : result;
    end
  end
`endif

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multi-cycle RV32I datapath driven by the multi-cycle control FSM. It sits directly downstream of the controller: it consumes every control strobe and mux select the FSM emits, and returns the current instruction opcode to it. It holds all architectural and non-architectural state: PC, IR, original PC, PC+4, ALU-out, data and operand registers, and the register file. It also drives a unified instruction/data memory port.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- sel_mem_addr  in  1  memory address: 0 = PC, 1 = alu_reg
- we_ir, we_pc, we_pc_plus_4, we_alu_reg, we_original_pc, we_rf, we_mem  in  1 each  register and memory write enables
- sel_alu_src_a  in  1  0 = PC or original_pc, 1 = operand register A
- sel_original_pc  in  1  when src_a = 0: 0 = PC, 1 = original_pc
- sel_alu_src_b  in  2  00 = operand B, 01 = immediate, 10 = constant 4, 11 = zero
- alu_op  in  2  00 = add, 01 = R-type decode, 10 = I-type decode, 11 = add
- sel_result  in  2  RF write data: 00 = alu_reg, 01 = data_reg, 10 = pc_plus_4, 11 = immediate
- opcode  out  7  IR[6:0] to FSM
- mem_addr  out  32  memory address
- mem_wdata  out  32  store data, equal to operand register B
- mem_we  out  1  memory write strobe
- mem_rdata  in  32  memory read data, combinational with respect to mem_addr

## Operation
- ALU result feeds PC (when we_pc), pc_plus_4 (when we_pc_plus_4), and alu_reg (when we_alu_reg).
- IR loads mem_rdata on we_ir.
- original_pc loads PC on we_original_pc, which captures the pre-increment PC.
- Registers that load every cycle, unconditionally:
  - data_reg ← mem_rdata
  - A ← RF[IR[19:15]]
  - B ← RF[IR[24:20]]
- Register file:
  - 32×32, two combinational read ports.
  - Write at the edge when we_rf, to rd = IR[11:7], with data from the result mux.
  - x0 always reads 0; writes to x0 are discarded.
  - No write-to-read bypass.
- Immediate, selected by IR opcode:
  - I-format for 0000011 and 0010011.
  - S-format for 0100011.
  - J-format for 1101111.
  - U-format for 0110111 (IR[31:12]<<12).
  - All others produce 0.
  - All immediates are sign-extended to 32 bits.
- ALU decode:
  - R-type funct3: 000 add, or sub if funct7[5]; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra if funct7[5]; 110 or; 111 and.
  - I-type: same table, except 000 is always add; 101 uses IR[30] to pick srai.
  - Shift amount is src_b[4:0]. Arithmetic wraps modulo 2^32.
- mem_we = we_mem & ~rst.

## Timing
- Reset values, applied at a clock edge with rst high:
  - PC = RESET_PC
  - IR = 32'h0000_0013 (nop), so opcode = 7'b0010011
  - original_pc, pc_plus_4, alu_reg, data_reg, A, B = 0
  - Register file contents are not reset.
- While rst is high:
  - mem_we = 0.
  - mem_addr = PC, or alu_reg, per sel_mem_addr.
- Fetch is a single cycle: mem_addr = PC, IR and PC+4 are captured at the same edge, and opcode updates the following cycle.
- Load latency: the address reaches mem_addr in the cycle after alu_reg is written; data_reg holds the read data one edge later; the RF write happens at the following edge.
- A store writes memory at the edge that ends the cycle with mem_we high. The write uses the mem_addr and mem_wdata present in that cycle.
- Simultaneous we_pc and we_original_pc: original_pc captures the old PC.
- Simultaneous we_rf and a read of the same register: the read returns the old value.
- Reset asserted mid-instruction aborts the instruction. The next fetch after rst deasserts is at RESET_PC.

## Configuration
- MC_DP_TRACE_EN defined: adds the following outputs.
  - trace_valid (1): pulses for one cycle when we_rf or mem_we is high.
  - trace_pc (32): original_pc.
  - trace_rd (5): rd, or 0 for a store.
  - trace_data (32): result-mux value, or mem_wdata for a store.
  - All trace outputs are 0 in reset.
- MC_DP_TRACE_EN undefined: these ports and their logic are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package mc_pkg:
  - opcode constants
  - alu_op, sel_alu_src_b and sel_result encodings
  - ALU function enum
  - immediate-format enum
- One sub-module, mc_regfile: 32×32, x0 hardwired to zero, two read ports, one write port.
- ALU, immediate generator and muxes stay in mc_datapath.

## Test plan
- Reset with RESET_PC = 0x100:
  - PC = 0x100, opcode = 0010011, mem_we = 0.
  - First fetch edge leaves PC = 0x104 and original_pc = 0x100.
- addi x5,x0,-3, with the FSM strobes for fetch / decode / exe-I / writeback → x5 = 0xFFFF_FFFD.
- x5 = 0x1234, sw x5,8(x0), then lw x6,8(x0) against a memory model:
  - The store writes address 8 with data 0x1234.
  - x6 = 0x1234.
- R-type with x1 = 5, x2 = 7:
  - sub x3,x1,x2 → x3 = 0xFFFF_FFFE.
  - sra x4,x3,x1 with x1 = 1 → x4 = 0xFFFF_FFFF.
- jal x1,+16 at PC 0x200 → PC = 0x210, x1 = 0x204.
- lui x7,0xABCDE → x7 = 0xABCD_E000.
- addi x0,x0,5 → x0 still reads 0.
- rst asserted during a load's memory-read cycle → no RF write occurs, and PC = RESET_PC.
